mem2uart_frames: RTL and testbench
==================================

// Module: mem2uart_frames
// PURPOSE
//  Reader side of the LPC capture ring buffer. Pulls captured frames out of the
//  8-byte frame slots in RAM and streams them, byte by byte, to the UART
//  transmitter over a valid/ready handshake. Each frame is cyctype_dir, then
//  addr[31:24], [23:16], [15:8], [7:0], then data, then an optional terminator.
//  Pulses frame_read after each frame so the ring buffer advances its read pointer.
// PARAMETERS
//  RAM_LATENCY  1      cycles from ram_read_en to valid ram_data (1..3)
//  APPEND_TERM  1      1: send TERM_BYTE after the 6 frame bytes; 0: send none
//  TERM_BYTE    8'h0A  framing byte appended when APPEND_TERM=1
// PORTS
//  clock        in   1  system clock
//  reset        in   1  synchronous, active-high
//  empty        in   1  ring buffer holds no unread frame
//  read_slot    in   5  slot index of the oldest unread frame
//  ram_addr     out  8  {slot[4:0], byte_idx[2:0]}
//  ram_read_en  out  1  read strobe, one cycle per byte
//  ram_data     in   8  RAM read data, valid RAM_LATENCY cycles after the strobe
//  uart_data    out  8  byte to transmit
//  uart_valid   out  1  uart_data valid; held until accepted
//  uart_ready   in   1  UART can accept; transfer = valid & ready on a clock edge
//  frame_read   out  1  one-cycle pulse: current slot fully sent
//  busy         out  1  high in every state except IDLE
// BEHAVIOUR
//  - Reset: all outputs 0, ram_addr=8'h00, state IDLE, byte_idx=0. Reset asserted
//    mid-frame aborts the frame. No frame_read pulse is issued and the frame is
//    re-sent from byte 0 after reset.
//  - Frame slot layout: offset 0 = {4'h0, cyctype_dir}, offsets 1..4 = addr,
//    MSB first, offset 5 = data. Offsets 6 and 7 are never read.
//  - FSM states: IDLE, FETCH, WAIT, SEND, DONE.
//    IDLE: if empty=0, latch read_slot into slot_q, set byte_idx=0, go to FETCH.
//      empty and read_slot are sampled only in IDLE.
//    FETCH (1 cycle): ram_read_en=1, ram_addr={slot_q, byte_idx}, go to WAIT.
//    WAIT (RAM_LATENCY cycles, counted by a down-counter): on the last cycle,
//      register ram_data into uart_data, set uart_valid=1, go to SEND.
//    SEND: hold uart_data and uart_valid until uart_ready=1. On transfer, drop
//      uart_valid the next cycle.
//      byte_idx<5: increment byte_idx, go to FETCH.
//      byte_idx=5 with APPEND_TERM: load TERM_BYTE, keep uart_valid=1, mark the
//        terminator pending, stay in SEND.
//      byte_idx=5 without APPEND_TERM, or terminator transferred: go to DONE.
//    DONE (1 cycle): frame_read=1, go to IDLE.
//  - The ring buffer must update empty and read_slot by the cycle after the
//    frame_read pulse. IDLE never samples in the same cycle as frame_read.
//  - Latency: if empty=0 is sampled in IDLE at cycle 0, uart_valid rises at
//    cycle 2+RAM_LATENCY. Each subsequent byte follows 2+RAM_LATENCY cycles
//    after the previous transfer. A ready-high terminator follows in 1 cycle.
//  - uart_ready while uart_valid=0 is ignored. uart_data must not change while
//    uart_valid=1 and uart_ready=0.
//  - Slot wrap-around (31 to 0) is the ring buffer's job. This block uses
//    read_slot verbatim.
//  - empty rising during a frame does not affect the frame in flight.
// STRUCTURE
//  - Shared package/include (lpc_sniffer_defs): FRAME_BYTES=6, SLOT_BITS=5,
//    per-slot byte offsets (OFS_TYPE=0, OFS_ADDR3..0=1..4, OFS_DATA=5), and the
//    FSM state encodings.
//  - Single module, no sub-modules. The WAIT latency counter stays inline.
// TESTING
//  1 Reset, then empty=1 held 50 cycles -> busy=0, ram_read_en never asserts,
//    uart_valid=0.
//  2 Slot 3 = {05,FE,DC,00,80,A5}, uart_ready=1 always, APPEND_TERM=1 ->
//    ram_addr 8'h18..8'h1D in order; uart bytes 05 FE DC 00 80 A5 0A; exactly one
//    frame_read pulse; first uart_valid 3 cycles after IDLE sees empty=0.
//  3 Same frame, uart_ready toggling randomly -> identical byte sequence,
//    uart_data stable while stalled, no byte dropped or duplicated.
//  4 Two frames back to back (slots 31 then 0, empty low throughout) ->
//    14 bytes in order, two frame_read pulses, addresses 8'hF8.. then 8'h00..
//  5 reset asserted during SEND of byte 3 -> outputs cleared next cycle, no
//    frame_read; after release the same slot is re-sent from byte 0.
//  6 RAM_LATENCY=3, APPEND_TERM=0 -> uart_data matches RAM model, 6 bytes only,
//    uart_valid rises 5 cycles after IDLE sees empty=0.

Source files
------------

// File: rtl/mem2uart_frames_pkg.sv
// Shared definitions for the capture ring-buffer reader: slot geometry,
// per-slot byte offsets and the reader FSM encoding.
package mem2uart_frames_pkg;

    localparam int FRAME_BYTES = 6;
    localparam int SLOT_BITS   = 5;

    localparam logic [2:0] OFS_TYPE  = 3'd0;
    localparam logic [2:0] OFS_ADDR3 = 3'd1;
    localparam logic [2:0] OFS_ADDR2 = 3'd2;
    localparam logic [2:0] OFS_ADDR1 = 3'd3;
    localparam logic [2:0] OFS_ADDR0 = 3'd4;
    localparam logic [2:0] OFS_DATA  = 3'd5;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_WAIT  = 3'd2,
        ST_SEND  = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    // RAM byte address of one byte inside an 8-byte frame slot.
    function automatic logic [7:0] slot_byte_addr(input logic [SLOT_BITS-1:0] slot,
                                                  input logic [2:0]           idx);
        return {slot, idx};
    endfunction

endpackage

// File: rtl/mem2uart_frames_if.sv
// Ring-buffer status, frame RAM read port and UART byte stream of the reader.
interface mem2uart_frames_if;
    import mem2uart_frames_pkg::*;

    logic                 empty;
    logic [SLOT_BITS-1:0] read_slot;
    logic [7:0]           ram_addr;
    logic                 ram_read_en;
    logic [7:0]           ram_data;
    logic [7:0]           uart_data;
    logic                 uart_valid;
    logic                 uart_ready;
    logic                 frame_read;
    logic                 busy;

    modport master (
        input  empty, read_slot, ram_data, uart_ready,
        output ram_addr, ram_read_en, uart_data, uart_valid, frame_read, busy
    );

    modport slave (
        output empty, read_slot, ram_data, uart_ready,
        input  ram_addr, ram_read_en, uart_data, uart_valid, frame_read, busy
    );

endinterface

// File: rtl/mem2uart_frames.sv
// Reader side of the capture ring buffer: fetches one 6-byte frame slot at a
// time from RAM and streams it byte by byte to the UART, then acknowledges it.
module mem2uart_frames
    import mem2uart_frames_pkg::*;
#(
    parameter int         RAM_LATENCY = 1,
    parameter bit         APPEND_TERM = 1'b1,
    parameter logic [7:0] TERM_BYTE   = 8'h0A
) (
    input logic               clock,
    input logic               reset,
    mem2uart_frames_if.master bus
);

    localparam logic [1:0] WAIT_LOAD = 2'(RAM_LATENCY - 1);

    state_t               state_r;
    logic [SLOT_BITS-1:0] slot_q_r;
    logic [2:0]           byte_idx_r;
    logic [1:0]           wait_cnt_r;
    logic                 term_pending_r;
    logic [7:0]           ram_addr_r;
    logic                 ram_read_en_r;
    logic [7:0]           uart_data_r;
    logic                 uart_valid_r;
    logic                 frame_read_r;
    logic                 busy_r;

    // Reader FSM; every output is a register updated on the state transition.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r        <= ST_IDLE;
            slot_q_r       <= '0;
            byte_idx_r     <= 3'd0;
            wait_cnt_r     <= 2'd0;
            term_pending_r <= 1'b0;
            ram_addr_r     <= 8'h00;
            ram_read_en_r  <= 1'b0;
            uart_data_r    <= 8'h00;
            uart_valid_r   <= 1'b0;
            frame_read_r   <= 1'b0;
            busy_r         <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (!bus.empty) begin
                        slot_q_r      <= bus.read_slot;
                        byte_idx_r    <= OFS_TYPE;
                        ram_addr_r    <= slot_byte_addr(bus.read_slot, OFS_TYPE);
                        ram_read_en_r <= 1'b1;
                        busy_r        <= 1'b1;
                        state_r       <= ST_FETCH;
                    end
                end
                ST_FETCH: begin
                    ram_read_en_r <= 1'b0;
                    wait_cnt_r    <= WAIT_LOAD;
                    state_r       <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (wait_cnt_r == 2'd0) begin
                        uart_data_r  <= bus.ram_data;
                        uart_valid_r <= 1'b1;
                        state_r      <= ST_SEND;
                    end else begin
                        wait_cnt_r <= wait_cnt_r - 2'd1;
                    end
                end
                ST_SEND: begin
                    if (uart_valid_r && bus.uart_ready) begin
                        if (term_pending_r) begin
                            term_pending_r <= 1'b0;
                            uart_valid_r   <= 1'b0;
                            frame_read_r   <= 1'b1;
                            state_r        <= ST_DONE;
                        end else if (byte_idx_r < OFS_DATA) begin
                            byte_idx_r    <= byte_idx_r + 3'd1;
                            ram_addr_r    <= slot_byte_addr(slot_q_r, byte_idx_r + 3'd1);
                            ram_read_en_r <= 1'b1;
                            uart_valid_r  <= 1'b0;
                            state_r       <= ST_FETCH;
                        end else if (APPEND_TERM) begin
                            // Terminator reuses the SEND state, so it goes out one cycle later.
                            uart_data_r    <= TERM_BYTE;
                            term_pending_r <= 1'b1;
                        end else begin
                            uart_valid_r <= 1'b0;
                            frame_read_r <= 1'b1;
                            state_r      <= ST_DONE;
                        end
                    end
                end
                ST_DONE: begin
                    frame_read_r <= 1'b0;
                    busy_r       <= 1'b0;
                    state_r      <= ST_IDLE;
                end
                default: begin
                    term_pending_r <= 1'b0;
                    ram_read_en_r  <= 1'b0;
                    uart_valid_r   <= 1'b0;
                    frame_read_r   <= 1'b0;
                    busy_r         <= 1'b0;
                    state_r        <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.ram_addr    = ram_addr_r;
    assign bus.ram_read_en = ram_read_en_r;
    assign bus.uart_data   = uart_data_r;
    assign bus.uart_valid  = uart_valid_r;
    assign bus.frame_read  = frame_read_r;
    assign bus.busy        = busy_r;

endmodule

// File: tb/tb_mem2uart_frames.sv
// Directed bench for mem2uart_frames: RAM models at latency 1 and 3, and a
// byte/address scoreboard checked at every UART transfer and RAM strobe.
module tb_mem2uart_frames;
    import mem2uart_frames_pkg::*;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    mem2uart_frames_if bus_a ();
    mem2uart_frames_if bus_b ();

    mem2uart_frames #(.RAM_LATENCY(1), .APPEND_TERM(1'b1), .TERM_BYTE(8'h0A)) dut_a (
        .clock(clock), .reset(reset), .bus(bus_a)
    );
    mem2uart_frames #(.RAM_LATENCY(3), .APPEND_TERM(1'b0), .TERM_BYTE(8'h0A)) dut_b (
        .clock(clock), .reset(reset), .bus(bus_b)
    );

    // RAM models: data is valid exactly RAM_LATENCY cycles after the strobe, 8'hEE otherwise.
    logic [7:0] mem_a [0:255];
    logic [7:0] mem_b [0:255];
    logic [7:0] pipe_a;
    logic [7:0] pipe_b [0:2];

    always @(posedge clock) begin
        pipe_a <= bus_a.ram_read_en ? mem_a[bus_a.ram_addr] : 8'hEE;
        pipe_b[0] <= bus_b.ram_read_en ? mem_b[bus_b.ram_addr] : 8'hEE;
        pipe_b[1] <= pipe_b[0];
        pipe_b[2] <= pipe_b[1];
    end
    assign bus_a.ram_data = pipe_a;
    assign bus_b.ram_data = pipe_b[2];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int frames = 0;
    int xfers = 0;
    int first_valid = -1;
    int start_cyc = 0;
    int fcount = 0;
    int x0 = 0;
    logic prev_stall = 1'b0;
    logic prev_v = 1'b0;
    logic prev_fr = 1'b0;
    logic [7:0] prev_data = 8'h00;
    logic [7:0] byte_q [$];
    logic [7:0] addr_q [$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: drive uart_ready at the negedge, then score what the next posedge will do.
    task automatic cycle(input bit sel, input int mode);
        logic v, r, re, fr;
        logic [7:0] d, ad;
        @(negedge clock);
        cyc++;
        r = (mode == 0) ? 1'b1 : (mode == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
        if (sel) begin
            bus_b.uart_ready = r;
            bus_a.uart_ready = 1'b0;
            v = bus_b.uart_valid; d = bus_b.uart_data; re = bus_b.ram_read_en;
            ad = bus_b.ram_addr; fr = bus_b.frame_read;
        end else begin
            bus_a.uart_ready = r;
            bus_b.uart_ready = 1'b0;
            v = bus_a.uart_valid; d = bus_a.uart_data; re = bus_a.ram_read_en;
            ad = bus_a.ram_addr; fr = bus_a.frame_read;
        end
        if (prev_stall) begin
            check("stall_valid", 32'(v), 32'd1);
            check("stall_data", 32'(d), 32'(prev_data));
        end
        if (re) begin
            if (addr_q.size() > 0) check("ram_addr", 32'(ad), 32'(addr_q.pop_front()));
            else check("unexpected_read_en", 32'(re), 32'd0);
        end
        if (v && !prev_v && first_valid < 0) first_valid = cyc;
        if (v && r) begin
            xfers++;
            if (byte_q.size() > 0) check("uart_byte", 32'(d), 32'(byte_q.pop_front()));
            else check("extra_byte", 32'(v && r), 32'd0);
        end
        if (fr) begin
            frames++;
            check("frame_read_pulse", 32'(prev_fr), 32'd0);
        end
        prev_stall = v && !r;
        prev_v = v;
        prev_fr = fr;
        prev_data = d;
    endtask

    task automatic load_frame(input bit sel, input logic [4:0] slot, input logic [47:0] fb,
                              input bit term);
        for (int i = 0; i < 6; i++) begin
            logic [7:0] b;
            b = fb[47-8*i -: 8];
            if (sel) mem_b[{slot, 3'(i)}] = b;
            else mem_a[{slot, 3'(i)}] = b;
            byte_q.push_back(b);
            addr_q.push_back({slot, 3'(i)});
        end
        if (term) byte_q.push_back(8'h0A);
    endtask

    task automatic run_until_frames(input bit sel, input int mode, input int target,
                                    input string tag);
        for (int i = 0; i < 400 && frames < target; i++) cycle(sel, mode);
        check(tag, 32'(frames), 32'(target));
    endtask

    task automatic check_cleared(input string tag);
        check({tag, "_valid"}, 32'(bus_a.uart_valid), 32'd0);
        check({tag, "_busy"}, 32'(bus_a.busy), 32'd0);
        check({tag, "_read_en"}, 32'(bus_a.ram_read_en), 32'd0);
        check({tag, "_frame_read"}, 32'(bus_a.frame_read), 32'd0);
        check({tag, "_ram_addr"}, 32'(bus_a.ram_addr), 32'h00);
        check({tag, "_uart_data"}, 32'(bus_a.uart_data), 32'h00);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            mem_a[i] = 8'(i) ^ 8'h5A;
            mem_b[i] = 8'(i) ^ 8'hA5;
        end
        reset = 1'b1;
        bus_a.empty = 1'b1; bus_a.read_slot = 5'd0; bus_a.uart_ready = 1'b0;
        bus_b.empty = 1'b1; bus_b.read_slot = 5'd0; bus_b.uart_ready = 1'b0;

        // Test 1: reset state, then an empty ring buffer for 50 cycles.
        for (int i = 0; i < 3; i++) cycle(1'b0, 2);
        check_cleared("reset");
        check("reset_b_valid", 32'(bus_b.uart_valid), 32'd0);
        reset = 1'b0;
        for (int i = 0; i < 50; i++) begin
            cycle(1'b0, 0);
            check("idle_busy", 32'(bus_a.busy), 32'd0);
            check("idle_valid", 32'(bus_a.uart_valid), 32'd0);
        end

        // Test 2: slot 3, ready always high, terminator appended.
        load_frame(1'b0, 5'd3, 48'h05FEDC0080A5, 1'b1);
        bus_a.read_slot = 5'd3;
        bus_a.empty = 1'b0;
        start_cyc = cyc; first_valid = -1; x0 = xfers;
        cycle(1'b0, 0);
        cycle(1'b0, 0);
        check("busy_in_frame", 32'(bus_a.busy), 32'd1);
        run_until_frames(1'b0, 0, 1, "t2_frame_done");
        bus_a.empty = 1'b1;
        check("t2_first_valid_latency", 32'(first_valid - start_cyc), 32'd3);
        for (int i = 0; i < 6; i++) cycle(1'b0, 0);
        check("t2_frames", 32'(frames), 32'd1);
        check("t2_bytes", 32'(xfers - x0), 32'd7);
        check("t2_byte_q_empty", 32'(byte_q.size()), 32'd0);
        check("t2_addr_q_empty", 32'(addr_q.size()), 32'd0);
        check("t2_busy_after", 32'(bus_a.busy), 32'd0);

        // Test 3: same frame, random back-pressure.
        load_frame(1'b0, 5'd3, 48'h05FEDC0080A5, 1'b1);
        bus_a.empty = 1'b0; x0 = xfers;
        run_until_frames(1'b0, 1, 2, "t3_frame_done");
        bus_a.empty = 1'b1;
        for (int i = 0; i < 6; i++) cycle(1'b0, 1);
        check("t3_bytes", 32'(xfers - x0), 32'd7);
        check("t3_byte_q_empty", 32'(byte_q.size()), 32'd0);

        // Test 4: slots 31 then 0 back to back.
        load_frame(1'b0, 5'd31, 48'h011234567890, 1'b1);
        load_frame(1'b0, 5'd0, 48'h02ABCDEF0123, 1'b1);
        bus_a.read_slot = 5'd31; bus_a.empty = 1'b0; x0 = xfers;
        run_until_frames(1'b0, 0, 3, "t4_first_frame");
        bus_a.read_slot = 5'd0;
        run_until_frames(1'b0, 0, 4, "t4_second_frame");
        bus_a.empty = 1'b1;
        for (int i = 0; i < 6; i++) cycle(1'b0, 0);
        check("t4_bytes", 32'(xfers - x0), 32'd14);
        check("t4_frames", 32'(frames), 32'd4);
        check("t4_addr_q_empty", 32'(addr_q.size()), 32'd0);

        // Test 5: reset while byte 3 waits in SEND, then the same slot restarts.
        load_frame(1'b0, 5'd3, 48'h05FEDC0080A5, 1'b1);
        bus_a.read_slot = 5'd3; bus_a.empty = 1'b0; x0 = xfers;
        for (int i = 0; i < 100 && xfers < x0 + 3; i++) cycle(1'b0, 0);
        check("t5_pre_reset_bytes", 32'(xfers - x0), 32'd3);
        cycle(1'b0, 2);
        for (int i = 0; i < 20 && !bus_a.uart_valid; i++) cycle(1'b0, 2);
        check("t5_byte3_valid", 32'(bus_a.uart_valid), 32'd1);
        check("t5_byte3_addr", 32'(bus_a.ram_addr), 32'h1B);
        check("t5_byte3_data", 32'(bus_a.uart_data), 32'h00);
        fcount = frames;
        reset = 1'b1; prev_stall = 1'b0; prev_v = 1'b0;
        cycle(1'b0, 2);
        check_cleared("t5_reset");
        byte_q.delete(); addr_q.delete();
        load_frame(1'b0, 5'd3, 48'h05FEDC0080A5, 1'b1);
        cycle(1'b0, 2);
        check("t5_no_frame_read", 32'(frames), 32'(fcount));
        reset = 1'b0; x0 = xfers;
        run_until_frames(1'b0, 0, fcount + 1, "t5_resent_frame");
        bus_a.empty = 1'b1;
        for (int i = 0; i < 6; i++) cycle(1'b0, 0);
        check("t5_resent_bytes", 32'(xfers - x0), 32'd7);
        check("t5_byte_q_empty", 32'(byte_q.size()), 32'd0);

        // Test 6: latency-3 RAM, no terminator.
        load_frame(1'b1, 5'd7, 48'h03C0FFEE1234, 1'b0);
        cycle(1'b1, 0);
        bus_b.read_slot = 5'd7; bus_b.empty = 1'b0;
        start_cyc = cyc; first_valid = -1; x0 = xfers; fcount = frames;
        run_until_frames(1'b1, 0, fcount + 1, "t6_frame_done");
        bus_b.empty = 1'b1;
        check("t6_first_valid_latency", 32'(first_valid - start_cyc), 32'd5);
        for (int i = 0; i < 10; i++) cycle(1'b1, 0);
        check("t6_bytes", 32'(xfers - x0), 32'd6);
        check("t6_byte_q_empty", 32'(byte_q.size()), 32'd0);
        check("t6_addr_q_empty", 32'(addr_q.size()), 32'd0);
        check("t6_busy_after", 32'(bus_b.busy), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
